// File: rtl/mult_n.sv
// Sequential shift-add multiplier with signed/unsigned operands and a full 2*WIDTH product.
// Each multiplication takes WIDTH iterations, then one sign-fix cycle, then a one-cycle done pulse.
module mult_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic               neg;

    logic               accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;

    always_comb begin
        abs_a      = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b      = (is_signed && b[WIDTH-1]) ? -b : b;
        // The adder is one bit wider than the operands so the carry lands in the shifted product.
        sum        = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        accept     = start && (state == IDLE || state == DONE);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            prod  <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                mcand <= abs_a;
                prod  <= {{WIDTH{1'b0}}, abs_b};
                neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                count <= '0;
            end else if (state == RUN) begin
                prod  <= {sum, prod[WIDTH-1:1]};
                count <= count + CW'(1);
            end else if (state == FIX && neg) begin
                prod  <= -prod;
            end
        end
    end

    assign hi   = prod[2*WIDTH-1:WIDTH];
    assign lo   = prod[WIDTH-1:0];
    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult_n.sv
// Randomized self-checking bench for mult_n at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_mult_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, sgn32, start8, sgn8;
    logic [31:0] a32, b32, hi32, lo32;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy32, done32, busy8, done8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_n #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32), .a(a32), .b(b32),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
    );

    mult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Extend both operands to 64 bits per mode, multiply, keep the low 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ea, eb, p;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
        ea = {32'b0, a} & mask;
        eb = {32'b0, b} & mask;
        if (s && a[w-1]) ea = ea | ~mask;
        if (s && b[w-1]) eb = eb | ~mask;
        p = ea * eb;
        return (w == 32) ? p : (p & 64'h0000_0000_0000_FFFF);
    endfunction

    function automatic logic [63:0] product(input bit w8);
        return w8 ? {48'b0, hi8, lo8} : {hi32, lo32};
    endfunction

    // Called #1 after an edge; that next edge accepts the op. Returns edges until done and busy cycles.
    task automatic do_op(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] got, output int edges, output int busy_cycles);
        if (w8) begin start8 = 1'b1; sgn8 = s; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin start32 = 1'b1; sgn32 = s; a32 = a; b32 = b; end
        @(posedge clk); #1;
        start8 = 1'b0;
        start32 = 1'b0;
        edges = 0;
        busy_cycles = 0;
        while (edges < 100) begin
            if (w8 ? busy8 : busy32) busy_cycles++;
            @(posedge clk); #1;
            edges++;
            if (w8 ? done8 : done32) break;
        end
        got = product(w8);
    endtask

    typedef struct {
        bit          w8;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [63:0] got;
        int          edges, bcyc, ndone, lat;
        bit          w8, s;
        logic [31:0] ra, rb;

        reset = 1'b0;
        start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0;  sgn8 = 1'b0;  a8 = '0;  b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset32", {30'b0, busy32, done32, hi32, lo32}, 64'h0);
        check("reset8",  {30'b0, busy8, done8, 16'b0, hi8, lo8}, 64'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        dir.push_back('{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001});
        dir.push_back('{0, 1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF});
        dir.push_back('{0, 1, 32'h80000000, 32'h80000000, 64'h40000000_00000000});
        dir.push_back('{0, 0, 32'h80000000, 32'h80000000, 64'h40000000_00000000});
        dir.push_back('{0, 1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000});
        dir.push_back('{0, 1, 32'h00000007, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6});
        dir.push_back('{1, 0, 32'hFF, 32'hFF, 64'hFE01});
        dir.push_back('{1, 1, 32'hFF, 32'h01, 64'hFFFF});
        dir.push_back('{1, 1, 32'h80, 32'h80, 64'h4000});
        dir.push_back('{1, 0, 32'h80, 32'h80, 64'h4000});
        dir.push_back('{1, 1, 32'h80, 32'hFF, 64'h0080});
        dir.push_back('{1, 1, 32'h07, 32'hFA, 64'hFFD6});

        foreach (dir[i]) begin
            do_op(dir[i].w8, dir[i].s, dir[i].a, dir[i].b, got, edges, bcyc);
            lat = dir[i].w8 ? 9 : 33;
            check($sformatf("dir%0d_prod", i), got, dir[i].exp);
            check($sformatf("dir%0d_latency", i), 64'(edges), 64'(lat));
            check($sformatf("dir%0d_busy", i), 64'(bcyc), 64'(lat));
            @(posedge clk); #1;
        end

        // start re-pulsed and operands scrambled while busy must not disturb 3*5
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd3; b32 = 32'd5;
        @(posedge clk); #1;
        ndone = 0;
        got = '0;
        for (int i = 0; i < 45; i++) begin
            if (i < 25) begin
                start32 = ~start32;
                a32 = (i < 2) ? 32'd9 : $urandom;
                b32 = (i < 2) ? 32'd9 : $urandom;
                sgn32 = 1'($urandom);
            end else begin
                start32 = 1'b0;
            end
            @(posedge clk); #1;
            if (done32) begin
                ndone++;
                if (ndone == 1) got = {hi32, lo32};
            end
        end
        check("busy_ignore_prod", got, 64'h0000000F);
        check("busy_ignore_ndone", 64'(ndone), 64'd1);

        // reset in the middle of RUN aborts without a done pulse
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd12345; b32 = 32'd678;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_state", {30'b0, busy32, done32, hi32, lo32}, 64'h0);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_op(0, 0, 32'd7, 32'd6, got, edges, bcyc);
        check("after_abort", got, 64'h2A);
        @(posedge clk); #1;

        // back-to-back: second start issued in the DONE cycle of the first op
        do_op(0, 0, 32'd2, 32'd3, got, edges, bcyc);
        check("b2b_first", got, 64'h6);
        do_op(0, 0, 32'd4, 32'd5, got, edges, bcyc);
        check("b2b_second", got, 64'h14);
        check("b2b_latency", 64'(edges), 64'd33);

        for (int i = 0; i < 1000; i++) begin
            w8 = (i % 2) == 1;
            s  = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 3) ra = w8 ? 32'h80 : 32'h80000000;
            if (i % 10 == 7) rb = w8 ? 32'hFF : 32'hFFFFFFFF;
            if (w8) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
            do_op(w8, s, ra, rb, got, edges, bcyc);
            check($sformatf("rnd%0d_w%0d_s%0d_%h_%h", i, w8 ? 8 : 32, s, ra, rb), got, ref_mul(w8 ? 8 : 32, s, ra, rb));
            check($sformatf("rnd%0d_latency", i), 64'(edges), w8 ? 64'd9 : 64'd33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
